// File: rtl/nios_tester_onchip_mem_arbiter_pkg.sv
// Shared constants for the nios_tester on-chip RAM arbiter.
//   PORT_A / PORT_B : port identifiers. They also index the one-hot grant
//                     vector: bit 0 is port A and bit 1 is port B.
//   DEF_ADDR_W      : default word address width (512-word RAM).
//   DEF_DATA_W      : default data width.
//   RD_LAT          : RAM read latency in cycles, from address clocked to
//                     data valid.
package nios_tester_onchip_mem_arbiter_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int RD_LAT     = 1;

endpackage

// File: rtl/nios_tester_onchip_mem_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter with a combinational one-hot grant.
//   clk, reset : clock and synchronous active-high reset.
//   req[1:0]   : request lines, indexed by port (PORT_A = bit 0, PORT_B = bit 1).
//   grant[1:0] : one-hot grant. It is all-zero while reset is high.
// last_grant comes out of reset as PORT_B, so port A wins the first
// contention. It moves to the winner on every grant and holds while no
// port is requesting.
module rr_arbiter_2
    import nios_tester_onchip_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == PORT_B) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_B;
        end else if (grant != 2'b00) begin
            last_grant <= grant[1] ? PORT_B : PORT_A;
        end
    end

endmodule

// File: rtl/nios_tester_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM of the nios_tester between two
// pipelined Avalon-MM slave ports: A (Nios) and B (test DMA / host bridge).
// At most one transfer is granted per cycle, chosen by round-robin. Read
// data is returned to its owner one cycle after the accept edge.
//   clk, reset          : single clock and synchronous active-high reset.
//   a_* / b_*           : Avalon-MM slave ports (address, byteenable, read,
//                         write, writedata, waitrequest, readdata,
//                         readdatavalid).
//   mem_*               : RAM port. mem_readdata comes back unregistered,
//                         one cycle after its address is clocked.
module nios_tester_onchip_mem_arbiter
    import nios_tester_onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,

    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic       req_a;
    logic       req_b;
    logic [1:0] grant;
    logic       grant_a;
    logic       grant_b;
    logic       accept_rd;
    logic       rd_pend;
    logic       rd_tag;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req_b, req_a}),
        .grant (grant)
    );

    assign grant_a = grant[PORT_A];
    assign grant_b = grant[PORT_B];

    // Both ports stall during reset. Otherwise an idle port sees
    // waitrequest low, so a new request can be taken in its first cycle.
    assign a_waitrequest = reset | (req_a & ~grant_a);
    assign b_waitrequest = reset | (req_b & ~grant_b);

    // With no grant the RAM port shows port A's address and byte lanes.
    // chipselect and write stay low, so the RAM ignores them.
    assign mem_address    = grant_b ? b_address    : a_address;
    assign mem_byteenable = grant_b ? b_byteenable : a_byteenable;
    assign mem_writedata  = grant_b ? b_writedata  : a_writedata;
    assign mem_chipselect = grant_a | grant_b;
    assign mem_write      = (grant_a & a_write) | (grant_b & b_write);
    assign mem_clken      = 1'b1;

    // A request with both read and write asserted is treated as a write.
    // It produces no read response.
    assign accept_rd = (grant_a & a_read & ~a_write) | (grant_b & b_read & ~b_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_tag  <= PORT_A;
        end else begin
            rd_pend <= accept_rd;
            rd_tag  <= grant_b ? PORT_B : PORT_A;
        end
    end

    // The strobe alone marks ownership; both ports see the raw RAM data.
    // It is also held off while reset is high, so no stale read completes
    // into a reset.
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;
    assign a_readdatavalid = rd_pend & (rd_tag == PORT_A) & ~reset;
    assign b_readdatavalid = rd_pend & (rd_tag == PORT_B) & ~reset;

endmodule

// File: tb/tb_nios_tester_onchip_mem_arbiter.sv
module tb_nios_tester_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  a_address, b_address;
    logic [3:0]  a_byteenable, b_byteenable;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_writedata, b_writedata;
    logic        a_waitrequest, b_waitrequest;
    logic [31:0] a_readdata, b_readdata;
    logic        a_readdatavalid, b_readdatavalid;
    logic [8:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nios_tester_onchip_mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
        .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
        .b_write(b_write), .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM: writes land at the clock edge; the read address is registered
    // and the data leaves the array unregistered.
    logic [31:0] ram [512];
    logic [8:0]  ram_addr_q;
    initial for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write)
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: shadow memory, last winner, pending read.
    logic [31:0] shadow [512];
    int          m_last = 1;
    bit          m_pend = 0;
    int          m_pend_port = 0;
    logic [31:0] m_pend_data = 0;
    initial for (int i = 0; i < 512; i++) shadow[i] = 32'h0;

    logic [31:0] a_rd_q[$], b_rd_q[$];
    int          grant_q[$];
    int          run_a = 0, run_b = 0, max_run = 0;

    always @(negedge clk) begin
        bit ra, rb, wr, rd;
        int win;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        ra = a_read | a_write;
        rb = b_read | b_write;
        if (reset)          win = -1;
        else if (ra && rb)  win = (m_last == 1) ? 0 : 1;
        else if (ra)        win = 0;
        else if (rb)        win = 1;
        else                win = -1;

        chk("a_waitrequest", a_waitrequest, reset | (ra & (win != 0)));
        chk("b_waitrequest", b_waitrequest, reset | (rb & (win != 1)));
        chk("mem_chipselect", mem_chipselect, win >= 0);
        chk("mem_clken", mem_clken, 1);
        chk("a_readdatavalid", a_readdatavalid, m_pend && m_pend_port == 0 && !reset);
        chk("b_readdatavalid", b_readdatavalid, m_pend && m_pend_port == 1 && !reset);
        if (m_pend && !reset)
            chk(m_pend_port == 0 ? "a_readdata" : "b_readdata",
                m_pend_port == 0 ? a_readdata : b_readdata, m_pend_data);

        addr = (win == 1) ? b_address : a_address;
        be   = (win == 1) ? b_byteenable : a_byteenable;
        wd   = (win == 1) ? b_writedata : a_writedata;
        wr   = (win == 0) ? a_write : (win == 1) ? b_write : 1'b0;
        rd   = (win == 0) ? a_read & ~a_write : (win == 1) ? b_read & ~b_write : 1'b0;
        chk("mem_write", mem_write, wr);
        chk("mem_address", mem_address, addr);
        chk("mem_byteenable", mem_byteenable, be);
        if (wr) chk("mem_writedata", mem_writedata, wd);

        // observations used by the directed checks
        if (a_readdatavalid) a_rd_q.push_back(a_readdata);
        if (b_readdatavalid) b_rd_q.push_back(b_readdata);
        if (!reset && ra && !a_waitrequest) grant_q.push_back(0);
        if (!reset && rb && !b_waitrequest) grant_q.push_back(1);
        run_a = (!reset && ra && a_waitrequest) ? run_a + 1 : 0;
        run_b = (!reset && rb && b_waitrequest) ? run_b + 1 : 0;
        if (run_a > max_run) max_run = run_a;
        if (run_b > max_run) max_run = run_b;

        // advance the model to the coming edge
        if (reset) begin
            m_last = 1;
            m_pend = 0;
        end else begin
            if (win >= 0) m_last = win;
            m_pend = rd;
            m_pend_port = win;
            if (rd) m_pend_data = shadow[addr];
            if (wr)
                for (int i = 0; i < 4; i++)
                    if (be[i]) shadow[addr][8*i +: 8] = wd[8*i +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
        a_byteenable = 4'hF; b_byteenable = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        idle();
        a_address = 0; b_address = 0; a_writedata = 0; b_writedata = 0;
        a_read = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_a_wait", a_waitrequest, 1);
            chk("rst_cs", mem_chipselect, 0);
            chk("rst_a_valid", a_readdatavalid, 0);
        end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("first_accept_wait", a_waitrequest, 0);
        tick(); idle(); tick(); tick();

        // A write then read back
        a_rd_q.delete(); b_rd_q.delete();
        a_write = 1; a_address = 9'h005; a_writedata = 32'hDEADBEEF; a_byteenable = 4'hF;
        tick();
        a_write = 0; a_read = 1;
        tick();
        idle();
        @(negedge clk);
        chk("rd_latency_valid", a_readdatavalid, 1);
        tick();
        chk("rd_a_count", a_rd_q.size(), 1);
        if (a_rd_q.size() > 0) chk("rd_deadbeef", a_rd_q[0], 32'hDEADBEEF);
        chk("rd_b_none", b_rd_q.size(), 0);

        // byte lanes at the top address
        a_rd_q.delete();
        a_write = 1; a_address = 9'h1FF; a_writedata = 32'h11223344; a_byteenable = 4'hF;
        tick();
        idle();
        b_write = 1; b_address = 9'h1FF; b_writedata = 32'hAA000000; b_byteenable = 4'h8;
        tick();
        idle();
        a_read = 1; a_address = 9'h1FF;
        tick(); idle(); tick(); tick();
        chk("lanes_count", a_rd_q.size(), 1);
        if (a_rd_q.size() > 0) chk("lanes_data", a_rd_q[0], 32'hAA223344);

        // contention: preload, make B the last winner, then both read
        a_write = 1; a_address = 9'h010; a_writedata = 32'h10101010;
        tick(); idle();
        b_write = 1; b_address = 9'h020; b_writedata = 32'h20202020;
        tick(); idle();
        a_rd_q.delete(); b_rd_q.delete(); grant_q.delete(); max_run = 0;
        a_read = 1; a_address = 9'h010; b_read = 1; b_address = 9'h020;
        repeat (8) tick();
        idle(); tick(); tick();
        chk("cont_grants", grant_q.size(), 8);
        for (int i = 0; i < 8 && i < grant_q.size(); i++)
            chk("cont_order", grant_q[i], i % 2);
        chk("cont_a_strobes", a_rd_q.size(), 4);
        chk("cont_b_strobes", b_rd_q.size(), 4);
        if (a_rd_q.size() > 0) chk("cont_a_data", a_rd_q[0], 32'h10101010);
        if (b_rd_q.size() > 0) chk("cont_b_data", b_rd_q[0], 32'h20202020);
        chk("cont_max_wait", max_run, 1);

        // mixed: A last, then A read and B write to the same word together
        a_write = 1; a_address = 9'h030; a_writedata = 32'h55555555;
        tick(); idle();
        a_rd_q.delete();
        a_read = 1; a_address = 9'h030;
        b_write = 1; b_address = 9'h030; b_writedata = 32'hCAFEF00D;
        @(negedge clk);
        chk("mixed_a_waits", a_waitrequest, 1);
        chk("mixed_b_wins", b_waitrequest, 0);
        tick();
        b_write = 0;
        tick(); idle(); tick(); tick();
        chk("mixed_count", a_rd_q.size(), 1);
        if (a_rd_q.size() > 0) chk("mixed_data", a_rd_q[0], 32'hCAFEF00D);

        // reset while a read is presented
        a_rd_q.delete();
        a_read = 1; reset = 1;
        tick();
        reset = 0; idle();
        tick(); tick();
        chk("rst_read_dropped", a_rd_q.size(), 0);

        // read accepted, reset raised in its response cycle
        a_read = 1; a_address = 9'h005;
        tick();
        idle(); reset = 1;
        @(negedge clk);
        chk("rst_mid_valid", a_readdatavalid, 0);
        tick();
        reset = 0;
        tick(); tick();
        chk("rst_mid_dropped", a_rd_q.size(), 0);

        // first contention after reset goes to A
        a_read = 1; b_read = 1; a_address = 9'h010; b_address = 9'h020;
        @(negedge clk);
        chk("post_rst_a_wins", a_waitrequest, 0);
        chk("post_rst_b_waits", b_waitrequest, 1);
        tick(); idle(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
